// File: rtl/game_stats_controller_if.sv
// Event and display bus between gameplay logic (master) and the stats controller (slave).
interface game_stats_controller_if;
  logic       new_game;
  logic       kill_evt;
  logic [1:0] kill_pts;
  logic       hit_evt;
  logic       freeze;
  logic       clk_display;
  logic [6:0] score;
  logic [1:0] lives;
  logic       lives_blank;
  logic       game_over;

  modport master (
    output new_game, kill_evt, kill_pts, hit_evt, freeze,
    input  clk_display, score, lives, lives_blank, game_over
  );

  modport slave (
    input  new_game, kill_evt, kill_pts, hit_evt, freeze,
    output clk_display, score, lives, lives_blank, game_over
  );
endinterface

// File: rtl/game_stats_controller.sv
// Score/lives bookkeeping, game-state FSM and display refresh strobe generator.
module game_stats_controller #(
  parameter int REFRESH_DIV   = 50000,
  parameter int BLINK_STROBES = 16,
  parameter int START_LIVES   = 3,
  parameter int SCORE_MAX     = 99
) (
  input logic               clk,
  input logic               rst,
  game_stats_controller_if.slave bus
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BLK_W = $clog2(BLINK_STROBES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'(BLINK_STROBES);
  localparam logic [6:0]       SCORE_TOP  = 7'(SCORE_MAX);
  localparam logic [1:0]       LIVES_INIT = 2'(START_LIVES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    HIT_BLINK = 2'd2,
    OVER      = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [DIV_W-1:0] div;
  logic             clk_display;
  logic [6:0]       score, score_next;
  logic [1:0]       lives, lives_next;
  logic             lives_blank, blank_next;
  logic             game_over, over_next;
  logic [BLK_W-1:0] blink_cnt, blink_next;

  // 8-bit sum so a score near the top can never wrap before saturating; 0 points counts as 1.
  function automatic logic [6:0] add_sat(input logic [6:0] cur, input logic [1:0] pts);
    logic [7:0] sum;
    sum = {1'b0, cur} + {6'd0, (pts == 2'd0) ? 2'd1 : pts};
    if (sum > {1'b0, SCORE_TOP}) begin
      return SCORE_TOP;
    end else begin
      return sum[6:0];
    end
  endfunction

  // Free-running refresh divider; keeps counting through freeze and every game state.
  always_ff @(posedge clk) begin
    if (rst) begin
      div         <= {DIV_W{1'b0}};
      clk_display <= 1'b0;
    end else if (div == DIV_LAST) begin
      div         <= {DIV_W{1'b0}};
      clk_display <= 1'b1;
    end else begin
      div         <= div + DIV_W'(1);
      clk_display <= 1'b0;
    end
  end

  // Next-state and next-value logic for the game FSM and its registered outputs.
  always_comb begin
    state_next = state;
    score_next = score;
    lives_next = lives;
    blank_next = lives_blank;
    over_next  = game_over;
    blink_next = blink_cnt;
    if (bus.new_game) begin
      score_next = 7'd0;
      lives_next = LIVES_INIT;
      blank_next = 1'b0;
      over_next  = 1'b0;
      blink_next = {BLK_W{1'b0}};
      state_next = PLAY;
    end else if (bus.freeze) begin
      state_next = state;
    end else begin
      case (state)
        IDLE: begin
          state_next = IDLE;
        end
        PLAY: begin
          if (bus.kill_evt) begin
            score_next = add_sat(score, bus.kill_pts);
          end else begin
            score_next = score;
          end
          // A hit in the same cycle as a kill still lands after the score update.
          if (bus.hit_evt && (lives > 2'd1)) begin
            lives_next = lives - 2'd1;
            blink_next = {BLK_W{1'b0}};
            blank_next = 1'b1;
            state_next = HIT_BLINK;
          end else if (bus.hit_evt) begin
            lives_next = 2'd0;
            over_next  = 1'b1;
            state_next = OVER;
          end else begin
            state_next = PLAY;
          end
        end
        HIT_BLINK: begin
          if (bus.kill_evt) begin
            score_next = add_sat(score, bus.kill_pts);
          end else begin
            score_next = score;
          end
          if (clk_display) begin
            if ((blink_cnt + BLK_W'(1)) == BLK_LAST) begin
              blink_next = BLK_LAST;
              blank_next = 1'b0;
              state_next = PLAY;
            end else begin
              blink_next = blink_cnt + BLK_W'(1);
              blank_next = ~lives_blank;
            end
          end else begin
            blink_next = blink_cnt;
          end
        end
        OVER: begin
          over_next = 1'b1;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // FSM state and game registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      score       <= 7'd0;
      lives       <= LIVES_INIT;
      lives_blank <= 1'b0;
      game_over   <= 1'b0;
      blink_cnt   <= {BLK_W{1'b0}};
    end else begin
      state       <= state_next;
      score       <= score_next;
      lives       <= lives_next;
      lives_blank <= blank_next;
      game_over   <= over_next;
      blink_cnt   <= blink_next;
    end
  end

  assign bus.clk_display = clk_display;
  assign bus.score       = score;
  assign bus.lives       = lives;
  assign bus.lives_blank = lives_blank;
  assign bus.game_over   = game_over;

endmodule

// File: tb/tb_game_stats_controller.sv
// Scoreboard bench for game_stats_controller with a cycle-level reference model.
module tb_game_stats_controller;
  localparam int RD = 4;
  localparam int BS = 4;
  localparam int SL = 3;
  localparam int SM = 99;
  localparam int M_IDLE = 0, M_PLAY = 1, M_BLINK = 2, M_OVER = 3;

  logic clk = 1'b0;
  logic rst;

  game_stats_controller_if bus();

  game_stats_controller #(
    .REFRESH_DIV(RD), .BLINK_STROBES(BS), .START_LIVES(SL), .SCORE_MAX(SM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int score;
    int lives;
    int blank;
    int over;
    int disp;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int strobes  = 0;
  int m_div, m_disp, m_state, m_score, m_lives, m_blank, m_cnt, m_over;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, push expectation, then pop and compare after the edge.
  task automatic step(input string tag, input bit r, input bit ng, input bit k,
                      input logic [1:0] p, input bit h, input bit f);
    exp_t e;
    int   pts;
    rst          = r;
    bus.new_game = ng;
    bus.kill_evt = k;
    bus.kill_pts = p;
    bus.hit_evt  = h;
    bus.freeze   = f;
    if (r) begin
      m_div = 0; m_disp = 0; m_state = M_IDLE; m_score = 0;
      m_lives = SL; m_blank = 0; m_cnt = 0; m_over = 0;
    end else begin
      pts = (p == 2'd0) ? 1 : int'(p);
      if (ng) begin
        m_score = 0; m_lives = SL; m_blank = 0; m_over = 0; m_cnt = 0; m_state = M_PLAY;
      end else if (!f) begin
        if (m_state == M_PLAY || m_state == M_BLINK) begin
          if (k) m_score = (m_score + pts > SM) ? SM : m_score + pts;
        end
        if (m_state == M_PLAY && h) begin
          if (m_lives > 1) begin
            m_lives--; m_cnt = 0; m_blank = 1; m_state = M_BLINK;
          end else begin
            m_lives = 0; m_over = 1; m_state = M_OVER;
          end
        end else if (m_state == M_BLINK && m_disp == 1) begin
          m_cnt++;
          if (m_cnt == BS) begin
            m_blank = 0; m_state = M_PLAY;
          end else begin
            m_blank = 1 - m_blank;
          end
        end
      end
      if (m_div == RD - 1) begin
        m_div = 0; m_disp = 1;
      end else begin
        m_div++; m_disp = 0;
      end
    end
    e.score = m_score; e.lives = m_lives; e.blank = m_blank; e.over = m_over; e.disp = m_disp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    strobes += int'(bus.clk_display);
    check({tag, "/score"}, int'(bus.score), e.score);
    check({tag, "/lives"}, int'(bus.lives), e.lives);
    check({tag, "/blank"}, int'(bus.lives_blank), e.blank);
    check({tag, "/game_over"}, int'(bus.game_over), e.over);
    check({tag, "/clk_display"}, int'(bus.clk_display), e.disp);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.new_game = 1'b0; bus.kill_evt = 1'b0; bus.kill_pts = 2'd0;
    bus.hit_evt = 1'b0; bus.freeze = 1'b0;

    // Reset, then idle with stray events that must be ignored.
    step("reset", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    step("reset", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    check("reset_score", int'(bus.score), 0);
    check("reset_lives", int'(bus.lives), SL);
    strobes = 0;
    for (int i = 0; i < 20; i++)
      step("idle", 1'b0, 1'b0, (i == 7), 2'd3, (i == 11), 1'b0);
    check("strobes_in_20", strobes, 5);
    check("idle_score", int'(bus.score), 0);

    // New game and basic scoring, including 0 points counting as 1.
    step("new_game", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    step("kill2", 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    check("score_after_2", int'(bus.score), 2);
    step("kill0", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    check("score_after_0", int'(bus.score), 3);
    idle("gap", 1);
    step("kill3", 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
    check("score_after_3", int'(bus.score), 6);

    // Climb to 97, then saturate at 99.
    for (int i = 0; i < 30; i++) step("climb", 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
    step("climb1", 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
    check("score_97", int'(bus.score), 97);
    step("sat_a", 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
    check("score_99", int'(bus.score), 99);
    step("sat_b", 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
    check("score_hold_99", int'(bus.score), 99);

    // Non-fatal hit, invulnerable blink, then back to PLAY (a second hit proves it).
    step("hit3", 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    check("lives_after_hit", int'(bus.lives), 2);
    check("blank_after_hit", int'(bus.lives_blank), 1);
    for (int i = 0; i < 30; i++)
      step("blink", 1'b0, 1'b0, 1'b0, 2'd0, (i == 3), 1'b0);
    check("lives_after_blink", int'(bus.lives), 2);
    check("blank_after_blink", int'(bus.lives_blank), 0);
    step("hit_play", 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    check("lives_hit_play", int'(bus.lives), 1);

    // Fatal hit together with a kill; OVER freezes everything until new_game.
    step("ng2", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    step("k2", 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    step("hitA", 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    idle("blinkA", 30);
    step("hitB", 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    idle("blinkB", 30);
    check("lives_one", int'(bus.lives), 1);
    step("fatal", 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
    check("fatal_score", int'(bus.score), 3);
    check("fatal_lives", int'(bus.lives), 0);
    check("fatal_over", int'(bus.game_over), 1);
    step("over_kill", 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
    step("over_hit", 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    idle("over", 6);
    check("over_score", int'(bus.score), 3);
    step("ng3", 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0);
    check("ng_score", int'(bus.score), 0);
    check("ng_lives", int'(bus.lives), SL);
    check("ng_over", int'(bus.game_over), 0);

    // Freeze drops events; freeze also pauses a blink; reset in the middle of a blink.
    step("k_pre", 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    strobes = 0;
    for (int i = 0; i < 8; i++)
      step("freeze", 1'b0, 1'b0, (i % 2 == 0), 2'd3, (i % 2 == 1), 1'b1);
    check("freeze_strobes", strobes, 2);
    check("freeze_score", int'(bus.score), 2);
    step("hit_f", 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step("blink_frz", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    idle("blink_run", 5);
    step("rst_mid", 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0);
    check("rst_mid_lives", int'(bus.lives), SL);
    check("rst_mid_blank", int'(bus.lives_blank), 0);
    step("post_rst_kill", 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
    idle("tail", 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
